// File: rtl/cond_logic_vec_if.sv
// rtl/cond_logic_vec_if.sv - control and result bundle for the predicated condition block
interface cond_logic_vec_if #(
  parameter int LANES = 4
);
  logic                 en;
  logic                 flush;
  logic [3:0]           cond;
  logic [4*LANES-1:0]   alu_flags;
  logic [1:0]           flag_w;
  logic [LANES-1:0]     lane_mask;
  logic                 pcs;
  logic                 reg_w;
  logic                 mem_w;
  logic                 pc_src;
  logic [LANES-1:0]     reg_write;
  logic [LANES-1:0]     mem_write;
  logic [LANES-1:0]     cond_ex;
  logic [4*LANES-1:0]   flags_q;

  modport master (
    output en, flush, cond, alu_flags, flag_w, lane_mask, pcs, reg_w, mem_w,
    input  pc_src, reg_write, mem_write, cond_ex, flags_q
  );

  modport slave (
    input  en, flush, cond, alu_flags, flag_w, lane_mask, pcs, reg_w, mem_w,
    output pc_src, reg_write, mem_write, cond_ex, flags_q
  );
endinterface

// File: rtl/cond_logic_vec.sv
// rtl/cond_logic_vec.sv - per-lane condition evaluation, qualified write enables and flag registers
module cond_logic_vec #(
  parameter int LANES    = 4,
  parameter int ROLLBACK = 1
) (
  input logic              clk,
  input logic              rst,
  cond_logic_vec_if.slave  bus
);

  logic [4*LANES-1:0] flags_q, flags_d;
  logic [4*LANES-1:0] snap_q, snap_d;
  logic [LANES-1:0]   cond_ex;
  logic [LANES-1:0]   qual;
  logic               any_upd;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = cy;
      4'h3:    r = !cy;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = cy & !z;
      4'h9:    r = !cy | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z & (n == v);
      4'hD:    r = z | (n != v);
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    flags_d = flags_q;
    snap_d  = snap_q;
    any_upd = 1'b0;
    cond_ex = '0;
    qual    = '0;
    for (int i = 0; i < LANES; i++) begin
      cond_ex[i] = eval_cond(bus.cond, flags_q[4*i +: 4]);
      qual[i]    = cond_ex[i] & bus.lane_mask[i] & !bus.flush;
      if (bus.en && qual[i]) begin
        if (bus.flag_w[1]) flags_d[4*i+2 +: 2] = bus.alu_flags[4*i+2 +: 2];
        if (bus.flag_w[0]) flags_d[4*i   +: 2] = bus.alu_flags[4*i   +: 2];
        if (bus.flag_w != 2'b00) any_upd = 1'b1;
      end
    end
    // Snapshot holds the state from just before the most recent real flag write
    if (ROLLBACK != 0 && any_upd) snap_d = flags_q;
    if (ROLLBACK != 0 && bus.flush) flags_d = snap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      snap_q  <= '0;
    end else begin
      flags_q <= flags_d;
      snap_q  <= snap_d;
    end
  end

  assign bus.cond_ex   = cond_ex;
  assign bus.pc_src    = bus.pcs & cond_ex[0] & !bus.flush;
  assign bus.reg_write = qual & {LANES{bus.reg_w}};
  assign bus.mem_write = qual & {LANES{bus.mem_w}};
  assign bus.flags_q   = flags_q;

endmodule
